// File: rtl/mmcm_drp_sequencer.sv
// mmcm_drp_sequencer
//   Applies a stream of masked register writes to an MMCM over its DRP port.
//   The sequence is: hold the MMCM in reset, then read-modify-write each
//   entry, release the reset and wait for LOCKED.
//   Each entry's mask selects which bits are kept: a mask bit of 1 keeps the
//   bit that was read back, and a mask bit of 0 takes the bit from entry_data.
//
// Ports
//   dclk, rst_n             DRP clock; asynchronous active-low reset
//   start                   one-cycle request, honoured only in IDLE/ERROR
//   entry_*                 register-write stream (valid/ready), entry_last ends it
//   daddr, di, den, dwe     DRP request outputs
//   drp_do, drdy            DRP response inputs ("do" is a SV keyword)
//   rst_mmcm                MMCM reset (registered)
//   locked                  MMCM LOCKED, asynchronous, synchronised here
//   busy, done, error       status; done is a one-cycle pulse
//   err_code                01 = drdy timeout, 10 = lock timeout
module mmcm_drp_sequencer #(
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        dclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        entry_valid,
  input  logic [6:0]  entry_addr,
  input  logic [15:0] entry_mask,
  input  logic [15:0] entry_data,
  input  logic        entry_last,
  output logic        entry_ready,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  output logic        den,
  output logic        dwe,
  input  logic [15:0] drp_do,
  input  logic        drdy,
  output logic        rst_mmcm,
  input  logic        locked,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);
  // Terminal counts: the counter is 0 in a state's first cycle, so the
  // N-th cycle in that state has count N-1.
  localparam logic [CW-1:0] DRDY_TC = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_TC = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, RST_ON, WAIT_ENTRY, RD, WAIT_RD, WR, WAIT_WR,
    RELEASE, WAIT_LOCK, DONE, ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      err_nxt;
  logic [CW-1:0]   cnt;
  logic [15:0]     mask_q, data_q;
  logic            last_q;
  logic            lock_s1, lock_s2;

  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    case (state)
      IDLE:       if (start) begin state_nxt = RST_ON; err_nxt = 2'b00; end
      RST_ON:     state_nxt = WAIT_ENTRY;
      WAIT_ENTRY: if (entry_valid) state_nxt = RD;
      RD:         state_nxt = WAIT_RD;
      // drdy is checked before the terminal count, so a response arriving
      // in the last allowed cycle still wins.
      WAIT_RD:
        if (drdy)                state_nxt = WR;
        else if (cnt == DRDY_TC) begin state_nxt = ERROR; err_nxt = 2'b01; end
      WR:         state_nxt = WAIT_WR;
      WAIT_WR:
        if (drdy)                state_nxt = last_q ? RELEASE : WAIT_ENTRY;
        else if (cnt == DRDY_TC) begin state_nxt = ERROR; err_nxt = 2'b01; end
      RELEASE:    state_nxt = WAIT_LOCK;
      WAIT_LOCK:
        if (lock_s2)             state_nxt = DONE;
        else if (cnt == LOCK_TC) begin state_nxt = ERROR; err_nxt = 2'b10; end
      DONE:       state_nxt = IDLE;
      ERROR:      if (start) begin state_nxt = RST_ON; err_nxt = 2'b00; end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      err_code <= 2'b00;
      cnt      <= '0;
      rst_mmcm <= 1'b0;
      daddr    <= '0;
      di       <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      lock_s1  <= 1'b0;
      lock_s2  <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_code <= err_nxt;
      lock_s1  <= locked;
      lock_s2  <= lock_s1;
      // Restart the timeout on every state change; free-running wrap while
      // parked elsewhere is harmless because only wait states compare it.
      cnt      <= (state_nxt != state) ? '0 : cnt + 1'b1;
      // High from RST_ON through RELEASE; ERROR leaves it untouched, so a
      // drdy timeout keeps the MMCM in reset.
      if (state_nxt == RST_ON)  rst_mmcm <= 1'b1;
      else if (state == RELEASE) rst_mmcm <= 1'b0;
      if (state == WAIT_ENTRY && entry_valid) begin
        daddr  <= entry_addr;
        mask_q <= entry_mask;
        data_q <= entry_data;
        last_q <= entry_last;
      end
      if (state == WAIT_RD && drdy)
        di <= (drp_do & mask_q) | (data_q & ~mask_q);
    end
  end

  assign den         = (state == RD) || (state == WR);
  assign dwe         = (state == WR);
  assign entry_ready = (state == WAIT_ENTRY);
  assign busy        = (state != IDLE) && (state != ERROR);
  assign done        = (state == DONE);
  assign error       = (state == ERROR);

endmodule

// File: doc/mmcm_drp_sequencer.md
MMCM_DRP_SEQUENCER -- requirements
Module: mmcm_drp_sequencer

Interface
REQ-001 SHALL have parameter DRDY_TIMEOUT, default 255: maximum cycles waited for drdy after a den strobe.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles waited for lock after reset release.
REQ-003 SHALL have port dclk, input, 1: the single clock, the same clock as the MMCM DRP port.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a reconfiguration sequence.
REQ-006 SHALL have ports entry_valid, entry_addr[6:0], entry_mask[15:0], entry_data[15:0], entry_last, all inputs: the register-write stream, with entry_last marking the final entry.
REQ-007 SHALL have port entry_ready, output, 1: the block accepts an entry when entry_valid and entry_ready are both high.
REQ-008 SHALL have ports daddr[6:0], di[15:0], den, dwe as outputs, and do[15:0], drdy as inputs: the DRP bus.
REQ-009 SHALL have port rst_mmcm, output, 1: reset to the MMCM.
REQ-010 SHALL have port locked, input, 1: the MMCM LOCKED signal, asynchronous to dclk.
REQ-011 SHALL have outputs busy (1), done (1, pulse), error (1) and err_code[1:0].

Function
REQ-012 SHALL implement states IDLE, RST_ON, WAIT_ENTRY, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK, DONE and ERROR.
REQ-013 SHALL act on start only in IDLE or ERROR, ignore start in all other states, and move to RST_ON on the next edge, clearing error and setting err_code to 0.
REQ-014 SHALL register rst_mmcm high from the RST_ON cycle through the end of RELEASE, and drive it low in RELEASE's successor.
REQ-015 SHALL drive entry_ready high only in WAIT_ENTRY; on acceptance it SHALL capture addr, mask, data and last, then go to RD.
REQ-016 SHALL in RD drive den=1, dwe=0 and daddr equal to the captured addr for exactly one cycle.
REQ-017 SHALL in WAIT_RD, on drdy, compute di = (do AND mask) OR (data AND NOT mask), with a mask bit of 1 meaning the existing bit is kept.
REQ-018 SHALL in WR drive den=1, dwe=1, the same daddr and the computed di for exactly one cycle.
REQ-019 SHALL in WAIT_WR, on drdy, go to RELEASE if the captured last is 1, else return to WAIT_ENTRY.
REQ-020 SHALL keep den and dwe at 0 in every state other than RD and WR; daddr and di SHALL hold their last values.
REQ-021 SHALL ignore drdy outside WAIT_RD and WAIT_WR.
REQ-022 SHALL use a timeout counter of width clog2(max(DRDY_TIMEOUT, LOCK_TIMEOUT)+1), cleared on every state entry.
REQ-023 SHALL, if DRDY_TIMEOUT cycles elapse in WAIT_RD or WAIT_WR without drdy, go to ERROR with err_code=01 and hold rst_mmcm high.
REQ-024 SHALL pass locked through a 2-flop synchronizer, and WAIT_LOCK SHALL exit to DONE on the first cycle the synchronized lock is 1.
REQ-025 SHALL, if LOCK_TIMEOUT cycles elapse in WAIT_LOCK, go to ERROR with err_code=10.
REQ-026 SHALL pulse done for exactly the one DONE cycle and then return to IDLE.
REQ-027 SHALL hold busy high in every state except IDLE and ERROR.
REQ-028 SHALL hold error high while in ERROR; rst_mmcm SHALL stay in its value at entry to ERROR.
REQ-029 SHALL apply a drdy that arrives on the same cycle as the timeout terminal count; the timeout SHALL NOT fire in that case.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force state to IDLE and drive den, dwe, rst_mmcm, entry_ready, busy, done and error to 0, with daddr, di and err_code at 0, and clear the synchronizer and counter.
REQ-031 SHALL, when reset occurs mid-sequence, discard the sequence with no partial completion reported; the caller SHALL rerun it.

Verification
REQ-032 Single entry (addr 0x08, mask 0x1000, data 0x0145, do=0xFFFF, drdy 2 cycles after each den), locked high 10 cycles after release -> di=0x1145; rst_mmcm high from RST_ON through RELEASE; done pulses once.
REQ-033 Three entries, last on the third, with entry_valid gapped -> exactly 3 reads and 3 writes, in order, and no den during gaps.
REQ-034 drdy never returns after a read -> ERROR DRDY_TIMEOUT cycles later, err_code=01, rst_mmcm=1; a subsequent start clears error.
REQ-035 locked held low -> err_code=10 after LOCK_TIMEOUT cycles in WAIT_LOCK; start pulsed while busy -> ignored.
REQ-036 rst_n asserted during WAIT_WR -> all outputs 0 immediately; a new start after rst_n=1 runs a clean sequence.
